mgmt_read_arbiter: RTL

- Shares one management register read port (rd_en/rd_addr/rd_len in, rd_valid/rd_data byte stream out) between NUM_PORTS requesters, e.g. a simulation bridge, a UART/SPI debug bridge and on-chip firmware.
- Sits between the requesters and the register interface, all in one clock domain.
- Queues one request per port, grants round-robin, and issues one downstream read at a time.
- Routes returned bytes to the owner only, and signals completion, or an error on stall timeout.

---
 rtl/mgmt_read_arbiter_if.sv | 29 ++
 rtl/mgmt_read_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mgmt_read_arbiter_if.sv
// Requester-side and register-side signals of the shared management read port.
// The arbiter uses the slave view; the requesters and register block together drive the master view.
interface mgmt_read_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]      req_rd_en;
    logic [16*NUM_PORTS-1:0]   req_rd_addr;
    logic [16*NUM_PORTS-1:0]   req_rd_len;
    logic [NUM_PORTS-1:0]      req_busy;
    logic [NUM_PORTS-1:0]      req_rd_valid;
    logic [7:0]                req_rd_data;
    logic [NUM_PORTS-1:0]      req_done;
    logic [NUM_PORTS-1:0]      req_err;
    logic                      rd_en;
    logic [15:0]               rd_addr;
    logic [15:0]               rd_len;
    logic                      rd_valid;
    logic [7:0]                rd_data;

    modport slave (
        input  req_rd_en, req_rd_addr, req_rd_len, rd_valid, rd_data,
        output req_busy, req_rd_valid, req_rd_data, req_done, req_err, rd_en, rd_addr, rd_len
    );

    modport master (
        output req_rd_en, req_rd_addr, req_rd_len, rd_valid, rd_data,
        input  req_busy, req_rd_valid, req_rd_data, req_done, req_err, rd_en, rd_addr, rd_len
    );
endinterface

// File: rtl/mgmt_read_arbiter.sv
// Round-robin sharing of one management read port; grant 1 cycle after capture, 1-cycle return path.
// No backpressure: one request queued per port, extra pulses while pending are dropped; stalls end in timeout.
module mgmt_read_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    mgmt_read_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int KW    = IDX_W + 1;
    localparam logic [15:0]      TMO      = 16'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

    state_e                     state_q, state_d;
    logic [NUM_PORTS-1:0]       pending_q, pending_d;
    logic [NUM_PORTS-1:0][15:0] slot_addr_q, slot_addr_d;
    logic [NUM_PORTS-1:0][15:0] slot_len_q, slot_len_d;
    logic [IDX_W-1:0]           owner_q, owner_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [15:0]                idle_q, idle_d;
    logic                       rd_en_q, rd_en_d;
    logic [15:0]                rd_addr_q, rd_addr_d;
    logic [15:0]                rd_len_q, rd_len_d;
    logic [NUM_PORTS-1:0]       rvld_q, rvld_d;
    logic [NUM_PORTS-1:0]       done_q, done_d;
    logic [NUM_PORTS-1:0]       err_q, err_d;
    logic [7:0]                 rdata_q, rdata_d;

    logic                       sel_vld;
    logic [IDX_W-1:0]           sel_idx;
    logic                       grant;

    // First pending port at or above the pointer, wrapping around.
    always_comb begin
        logic [KW-1:0] k;
        sel_vld = 1'b0;
        sel_idx = '0;
        k       = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            k = {1'b0, ptr_q} + KW'(j);
            if (k >= KW'(NUM_PORTS)) begin
                k = k - KW'(NUM_PORTS);
            end
            if (!sel_vld && pending_q[k[IDX_W-1:0]]) begin
                sel_vld = 1'b1;
                sel_idx = k[IDX_W-1:0];
            end
        end
    end

    assign grant = (state_q == S_IDLE) && sel_vld;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        slot_addr_d = slot_addr_q;
        slot_len_d  = slot_len_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_len_d    = rd_len_q;
        done_d      = '0;
        err_d       = '0;
        rvld_d      = '0;
        rdata_d     = bus.rd_data;

        if (state_q == S_WAIT && bus.rd_valid) begin
            rvld_d[owner_q] = 1'b1;
        end

        if (grant) begin
            pending_d[sel_idx] = 1'b0;
            owner_d            = sel_idx;
            ptr_d              = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
            if (slot_len_q[sel_idx] != 16'd0) begin
                rd_en_d   = 1'b1;
                rd_addr_d = slot_addr_q[sel_idx];
                rd_len_d  = slot_len_q[sel_idx];
                cnt_d     = '0;
                idle_d    = '0;
                state_d   = S_WAIT;
            end else begin
                done_d[sel_idx] = 1'b1;
            end
        end

        if (state_q == S_WAIT) begin
            if (bus.rd_valid) begin
                cnt_d  = cnt_q + 16'd1;
                idle_d = '0;
                if (cnt_q == rd_len_q - 16'd1) begin
                    state_d         = S_IDLE;
                    done_d[owner_q] = 1'b1;
                end
            end else begin
                idle_d = idle_q + 16'd1;
                if (idle_d == TMO) begin
                    state_d        = S_IDLE;
                    err_d[owner_q] = 1'b1;
                end
            end
        end

        // Capture sees pending after the grant clear, so a pulse on the grant edge is kept.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.req_rd_en[i] && !pending_d[i]) begin
                pending_d[i]   = 1'b1;
                slot_addr_d[i] = bus.req_rd_addr[16*i +: 16];
                slot_len_d[i]  = bus.req_rd_len[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            slot_addr_q <= '0;
            slot_len_q  <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_len_q    <= '0;
            rvld_q      <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            slot_addr_q <= slot_addr_d;
            slot_len_q  <= slot_len_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_len_q    <= rd_len_d;
            rvld_q      <= rvld_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.req_busy     = pending_q |
                              ((state_q == S_WAIT) ? (NUM_PORTS'(1) << owner_q) : '0);
    assign bus.req_rd_valid = rvld_q;
    assign bus.req_rd_data  = rdata_q;
    assign bus.req_done     = done_q;
    assign bus.req_err      = err_q;
    assign bus.rd_en        = rd_en_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.rd_len       = rd_len_q;
endmodule
